axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master round-robin AXI read arbiter onto one shared slave
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [1:0]        m0_arburst,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    output logic              m0_rlast,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [1:0]        m1_arburst,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    output logic              m1_rlast,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    output logic [1:0]        s_arburst,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    input  logic              s_rlast,
    output logic              s_rready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [7:0]  beat_q, beat_d;
    logic        len_err_q, len_err_d;

    logic              own_arvalid;
    logic [ADDR_W-1:0] own_araddr;
    logic [1:0]        own_arburst;
    logic [7:0]        own_arlen;
    logic [2:0]        own_arsize;
    logic              own_rready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            arlen_q      <= 8'd0;
            beat_q       <= 8'd0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            arlen_q      <= arlen_d;
            beat_q       <= beat_d;
            len_err_q    <= len_err_d;
        end
    end

    // Owner-side view of both channels; only meaningful while grant_q is non-zero.
    always_comb begin
        own_arvalid = grant_q[1] ? m1_arvalid : m0_arvalid;
        own_araddr  = grant_q[1] ? m1_araddr  : m0_araddr;
        own_arburst = grant_q[1] ? m1_arburst : m0_arburst;
        own_arlen   = grant_q[1] ? m1_arlen   : m0_arlen;
        own_arsize  = grant_q[1] ? m1_arsize  : m0_arsize;
        own_rready  = grant_q[1] ? m1_rready  : m0_rready;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        arlen_d      = arlen_q;
        beat_d       = beat_q;
        len_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m0_arvalid && m1_arvalid) begin
                    grant_d = last_grant_q ? 2'b01 : 2'b10;
                    state_d = S_ADDR;
                end else if (m0_arvalid) begin
                    grant_d = 2'b01;
                    state_d = S_ADDR;
                end else if (m1_arvalid) begin
                    grant_d = 2'b10;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                // A withdrawn request forfeits its turn without counting as served.
                if (!own_arvalid) begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end else if (s_arready) begin
                    arlen_d = own_arlen;
                    beat_d  = 8'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (s_rvalid && own_rready) begin
                    beat_d = beat_q + 8'd1;
                    if (s_rlast) begin
                        len_err_d    = (beat_q != arlen_q);
                        last_grant_d = grant_q[1];
                        grant_d      = 2'b00;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arburst  = 2'b00;
        s_arlen    = 8'd0;
        s_arsize   = 3'd0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_rready   = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m0_rlast   = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_rlast   = 1'b0;
        case (state_q)
            S_ADDR: begin
                s_arvalid  = own_arvalid;
                s_araddr   = own_araddr;
                s_arburst  = own_arburst;
                s_arlen    = own_arlen;
                s_arsize   = own_arsize;
                m0_arready = grant_q[0] & s_arready;
                m1_arready = grant_q[1] & s_arready;
            end
            S_DATA: begin
                s_rready = own_rready;
                if (grant_q[1]) begin
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rvalid = s_rvalid;
                    m1_rlast  = s_rlast;
                end else begin
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rvalid = s_rvalid;
                    m0_rlast  = s_rlast;
                end
            end
            default: ;
        endcase
    end

    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - randomized and directed bench for axi_rd_arbiter against a transaction-level model
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] araddr [2];
    logic        arvalid [2];
    logic [1:0]  arburst [2];
    logic [7:0]  arlen [2];
    logic [2:0]  arsize [2];
    logic        rready [2];
    logic        arready [2];
    logic [63:0] rdata [2];
    logic [1:0]  rresp [2];
    logic        rvalid [2];
    logic        rlast [2];

    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic [1:0]  s_arburst;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic        s_arready;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rlast;
    logic        s_rready;
    logic [1:0]  grant;
    logic        busy;
    logic        len_err;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
        .m0_arburst(arburst[0]), .m0_arlen(arlen[0]), .m0_arsize(arsize[0]),
        .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rvalid(rvalid[0]), .m0_rlast(rlast[0]),
        .m0_rready(rready[0]),
        .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
        .m1_arburst(arburst[1]), .m1_arlen(arlen[1]), .m1_arsize(arsize[1]),
        .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rvalid(rvalid[1]), .m1_rlast(rlast[1]),
        .m1_rready(rready[1]),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arburst(s_arburst), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
        .s_rready(s_rready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scenario controls, written only by the main sequence.
    int          req_tot [2] = '{0, 0};
    int          drop_tot [2] = '{0, 0};
    int          stall_end [2] = '{-1, -1};
    logic [31:0] fix_addr [2] = '{32'h0, 32'h0};
    logic [7:0]  fix_len [2] = '{8'd0, 8'd0};
    bit          rnd = 1'b0;
    int          sar_mode = 0;
    int          early_n = 0;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Master and slave agents: sample handshakes mid-cycle, drive just after the edge.
    int          req_done [2] = '{0, 0};
    int          drop_done [2] = '{0, 0};
    int          sent = 0;
    bit          sl_active = 1'b0;
    logic [31:0] sl_addr = 32'h0;
    int          sl_idx = 0;
    int          sl_n = 0;
    initial begin
        bit          hs_ar [2];
        bit          hs_sar, hs_r;
        logic [31:0] cap_addr;
        logic [7:0]  cap_len;
        for (int i = 0; i < 2; i++) begin
            arvalid[i] = 1'b0; araddr[i] = 32'h0; arburst[i] = 2'd0;
            arlen[i] = 8'd0; arsize[i] = 3'd0; rready[i] = 1'b1;
        end
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = 64'h0; s_rresp = 2'd0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) hs_ar[i] = arvalid[i] && arready[i];
            hs_sar   = s_arvalid && s_arready;
            hs_r     = s_rvalid && s_rready;
            cap_addr = s_araddr;
            cap_len  = s_arlen;
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    arvalid[i] = 1'b0;
                    req_done[i] = req_tot[i];
                    drop_done[i] = drop_tot[i];
                end
                sl_active = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; sent = 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (arvalid[i] && hs_ar[i]) arvalid[i] = 1'b0;
                    if (arvalid[i] && drop_done[i] < drop_tot[i]) begin
                        arvalid[i] = 1'b0;
                        drop_done[i]++;
                    end
                    if (!arvalid[i] && req_done[i] < req_tot[i] && (!rnd || $urandom_range(0, 2) == 0)) begin
                        arvalid[i] = 1'b1;
                        araddr[i]  = rnd ? ($urandom() & 32'hFFFF_FFF8) : fix_addr[i];
                        arlen[i]   = rnd ? 8'($urandom_range(0, 7)) : fix_len[i];
                        arburst[i] = 2'($urandom_range(0, 2));
                        arsize[i]  = 3'($urandom_range(0, 3));
                        req_done[i]++;
                    end
                    rready[i] = (cyc <= stall_end[i]) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
                end
                if (hs_r) begin
                    sl_idx++;
                    sent++;
                    if (sl_idx == sl_n) sl_active = 1'b0;
                    s_rvalid = 1'b0;
                end
                if (hs_sar) begin
                    sl_active = 1'b1;
                    sl_addr   = cap_addr;
                    sl_idx    = 0;
                    if (early_n > 0) sl_n = early_n;
                    else if (rnd && $urandom_range(0, 4) == 0) sl_n = $urandom_range(1, int'(cap_len) + 2);
                    else sl_n = int'(cap_len) + 1;
                end
                if (!sl_active) s_rvalid = 1'b0;
                else if (!s_rvalid) s_rvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_rdata   = {sl_addr, 32'(sl_idx)};
                s_rresp   = 2'(sl_idx);
                s_rlast   = sl_active && (sl_idx == sl_n - 1);
                s_arready = (sar_mode == 0) ? 1'b1 : (sar_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
    end

    // Transaction-level reference: who owns the slave, whether the address or the data
    // is outstanding, and which master is next in line.
    int          owner;
    int          phase;
    int          last_owner;
    int          m_len, m_cnt;
    bit          exp_err;
    logic [1:0]  gseq [$];
    int          gaps [$];
    int          gap;
    logic [1:0]  prev_grant;
    int          err_pulses, srlow;
    int          rx_cnt [2], rlast_cnt [2], rx_idx [2];
    logic [31:0] rx_addr [2];

    initial forever begin
        int o;
        bit in_a, in_d;
        @(negedge clk);
        if (!rst) begin
            owner = -1; phase = 0; last_owner = 1; m_len = 0; m_cnt = 0; exp_err = 1'b0;
            gseq.delete(); gaps.delete(); gap = 0; prev_grant = 2'b00;
            err_pulses = 0; srlow = 0;
            for (int i = 0; i < 2; i++) begin
                rx_cnt[i] = 0; rlast_cnt[i] = 0; rx_idx[i] = 0; rx_addr[i] = 32'h0;
            end
        end else begin
            o    = (owner < 0) ? 0 : owner;
            in_a = (phase == 1);
            in_d = (phase == 2);
            chk("grant", 96'(grant), 96'((owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10)));
            chk("busy", 96'(busy), 96'(owner >= 0));
            chk("len_err", 96'(len_err), 96'(exp_err));
            chk("s_arvalid", 96'(s_arvalid), 96'(in_a && arvalid[o]));
            if (in_a)
                chk("s_ar_fields", 96'({s_araddr, s_arlen, s_arburst, s_arsize}),
                    96'({araddr[o], arlen[o], arburst[o], arsize[o]}));
            chk("s_rready", 96'(s_rready), 96'(in_d && rready[o]));
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d_arready", i), 96'(arready[i]), 96'((in_a && i == o) ? s_arready : 1'b0));
                chk($sformatf("m%0d_r_chan", i), 96'({rvalid[i], rlast[i], rresp[i], rdata[i]}),
                    (in_d && i == o) ? 96'({s_rvalid, s_rlast, s_rresp, s_rdata}) : 96'(0));
                if (arvalid[i] && arready[i]) begin
                    rx_addr[i] = araddr[i];
                    rx_idx[i]  = 0;
                end
                if (rvalid[i] && rready[i]) begin
                    chk($sformatf("m%0d_beat_data", i), 96'(rdata[i]), 96'({rx_addr[i], 32'(rx_idx[i])}));
                    rx_idx[i]++;
                    rx_cnt[i]++;
                    if (rlast[i]) rlast_cnt[i]++;
                end
            end
            if (len_err) err_pulses++;
            if (in_d && !s_rready) srlow++;
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                gseq.push_back(grant);
                if (gseq.size() > 1) gaps.push_back(gap);
                gap = 0;
            end
            if (grant == 2'b00) gap++;
            prev_grant = grant;

            exp_err = 1'b0;
            case (phase)
                0: if (arvalid[0] || arvalid[1]) begin
                    if (arvalid[0] && arvalid[1]) owner = 1 - last_owner;
                    else owner = arvalid[0] ? 0 : 1;
                    phase = 1;
                end
                1: if (!arvalid[o]) begin
                    owner = -1; phase = 0;
                end else if (s_arready) begin
                    m_len = int'(arlen[o]); m_cnt = 0; phase = 2;
                end
                default: if (s_rvalid && rready[o]) begin
                    if (s_rlast) begin
                        exp_err = (m_cnt != m_len);
                        last_owner = o; owner = -1; phase = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
        end
    end

    function automatic logic [15:0] gpack();
        logic [15:0] r = 16'h0;
        foreach (gseq[k]) r = (r << 2) | 16'(gseq[k]);
        return r;
    endfunction

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!busy && !arvalid[0] && !arvalid[1] && req_done[0] == req_tot[0] &&
                     req_done[1] == req_tot[1]) && n < budget);
        if (n >= budget) bound_fail(nm);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_beats(input int m, input int nb, input string nm);
        int n = 0;
        while (rx_cnt[m] < nb && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) bound_fail(nm);
    endtask

    initial begin
        int n;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 96'(grant), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_valids", 96'({s_arvalid, s_rready, arready[0], arready[1], rvalid[0], rvalid[1], len_err}), 96'(0));
        #2 rst = 1'b1;

        // Single m0 burst of 8 beats.
        do_reset();
        fix_addr[0] = 32'h8000_0040; fix_len[0] = 8'd7;
        req_tot[0]++;
        n = 0;
        do begin @(negedge clk); n++; end while (!arvalid[0] && n < 20);
        chk("lat_idle_s_arvalid", 96'(s_arvalid), 96'(0));
        @(negedge clk);
        chk("lat_s_arvalid", 96'(s_arvalid), 96'(1));
        chk("lat_s_araddr", 96'(s_araddr), 96'(32'h8000_0040));
        chk("lat_grant", 96'(grant), 96'(2'b01));
        wait_done("single", 200);
        chk("single_beats", 96'(rx_cnt[0]), 96'(8));
        chk("single_rlast", 96'(rlast_cnt[0]), 96'(1));
        chk("single_m1_beats", 96'(rx_cnt[1]), 96'(0));
        chk("single_len_err", 96'(err_pulses), 96'(0));

        // Simultaneous requests from reset.
        do_reset();
        fix_len[0] = 8'd3; fix_len[1] = 8'd3;
        fix_addr[0] = 32'h0000_1000; fix_addr[1] = 32'h0000_2000;
        req_tot[0]++; req_tot[1]++;
        wait_done("simul", 300);
        chk("simul_order", 96'(gpack()), 96'(4'b01_10));
        chk("simul_gap", 96'((gaps.size() > 0) ? gaps[0] : -1), 96'(1));

        // Both masters requesting continuously.
        do_reset();
        fix_len[0] = 8'd1; fix_len[1] = 8'd1;
        req_tot[0] += 2; req_tot[1] += 2;
        wait_done("fair", 300);
        chk("fair_order", 96'(gpack()), 96'(8'b01_10_01_10));

        // m1 backpressure mid-burst.
        do_reset();
        fix_len[1] = 8'd7; fix_addr[1] = 32'h0000_3000;
        req_tot[1]++;
        wait_beats(1, 3, "bp_beats");
        stall_end[1] = cyc + 3;
        wait_done("bp", 200);
        chk("bp_beats", 96'(rx_cnt[1]), 96'(8));
        chk("bp_stall_cycles", 96'(srlow), 96'(3));
        chk("bp_rlast", 96'(rlast_cnt[1]), 96'(1));

        // Slave ends the burst early.
        do_reset();
        fix_len[0] = 8'd7; early_n = 4;
        req_tot[0]++;
        wait_done("early", 200);
        early_n = 0;
        chk("early_beats", 96'(rx_cnt[0]), 96'(4));
        chk("early_err_pulses", 96'(err_pulses), 96'(1));
        chk("early_grant", 96'(grant), 96'(0));

        // Withdrawn request leaves round-robin history untouched.
        do_reset();
        sar_mode = 1;
        fix_len[0] = 8'd1; fix_len[1] = 8'd1;
        req_tot[0]++;
        n = 0;
        do begin @(negedge clk); n++; end while (grant != 2'b01 && n < 50);
        if (n >= 50) bound_fail("abort_grant");
        @(negedge clk);
        drop_tot[0]++;
        n = 0;
        do begin @(negedge clk); n++; end while (grant != 2'b00 && n < 50);
        if (n >= 50) bound_fail("abort_release");
        sar_mode = 0;
        req_tot[0]++; req_tot[1]++;
        wait_done("abort", 300);
        chk("abort_order", 96'(gpack()), 96'(6'b01_01_10));

        // Reset in the middle of a burst.
        do_reset();
        fix_len[0] = 8'd7;
        req_tot[0]++;
        wait_beats(0, 3, "mid_rst_beats");
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_grant_busy", 96'({grant, busy, len_err}), 96'(0));
        chk("mid_rst_valids", 96'({s_arvalid, s_rready, arready[0], arready[1], rvalid[0], rvalid[1], rlast[0], rlast[1]}), 96'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        fix_len[1] = 8'd3;
        req_tot[1]++;
        wait_done("post_rst", 200);
        chk("post_rst_m1_beats", 96'(rx_cnt[1]), 96'(4));
        chk("post_rst_m0_rlast", 96'(rlast_cnt[0]), 96'(0));
        chk("post_rst_m1_rlast", 96'(rlast_cnt[1]), 96'(1));

        // Randomized traffic on every control.
        do_reset();
        rnd = 1'b1; sar_mode = 2;
        req_tot[0] += 40; req_tot[1] += 40;
        wait_done("random", 20000);
        chk("random_beats", 96'(rx_cnt[0] + rx_cnt[1]), 96'(sent));
        chk("random_txns", 96'(rlast_cnt[0] + rlast_cnt[1]), 96'(80));
        rnd = 1'b0; sar_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
